// File: rtl/parity_pkg.sv
// Shared defaults and the stage-1 payload type for the parity checker.
package parity_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int CNT_W_DEF     = 16;
    localparam int PAYLOAD_LANES = DATA_W_DEF / 8;

    // Stage-1 register contents; sized for the default data width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]    data;
        logic [PAYLOAD_LANES-1:0] lanes;
        logic                     parity;
        logic                     mode;
        logic                     valid;
    } s1_payload_t;

endpackage

// File: rtl/parity_lane_xor.sv
// Per-byte XOR reduction: one parity bit per byte lane of the input word.
module parity_lane_xor #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]   i_data,
    output logic [DATA_W/8-1:0] o_lanes
);

    for (genvar g = 0; g < DATA_W / 8; g++) begin : g_lane
        assign o_lanes[g] = ^i_data[8*g +: 8];
    end

endmodule

// File: rtl/parity_checker.sv
// Two-stage even/odd parity checker with valid/ready flow control.
// Define PARITY_CHECKER_ERR_CNT_EN to build the saturating error counter.
module parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_error,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              err_clear
);

    localparam int LANES = DATA_W / 8;

    // Handshake: a word moves on valid & ready at a rising edge; the
    // pipeline advances as a whole unless the output is valid and not taken.
    s1_payload_t      r_s1;
    s1_payload_t      w_s1_next;
    logic [LANES-1:0] w_lanes;
    logic             w_stall;
    logic             w_accept;
    logic             w_expected;
    logic             w_s1_error;
    logic             w_err_hs;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_error;
    logic              r_err_sticky;

    parity_lane_xor #(.DATA_W(DATA_W)) u_lane_xor (
        .i_data  (in_data),
        .o_lanes (w_lanes)
    );

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~rst & ~w_stall;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_s1_next        = '0;
        w_s1_next.data   = DATA_W_DEF'(in_data);
        w_s1_next.lanes  = PAYLOAD_LANES'(w_lanes);
        w_s1_next.parity = in_parity;
        w_s1_next.mode   = odd_mode;
        w_s1_next.valid  = w_accept;
    end

    // Odd mode expects the inverted XOR, so folding the mode bit in suffices.
    assign w_expected = (^r_s1.lanes[LANES-1:0]) ^ r_s1.mode;
    assign w_s1_error = r_s1.valid & (r_s1.parity != w_expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_error <= 1'b0;
        end else if (!w_stall) begin
            r_s1        <= w_s1_next;
            r_out_valid <= r_s1.valid;
            r_out_data  <= r_s1.data[DATA_W-1:0];
            r_out_error <= w_s1_error;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_error = r_out_error;

    assign w_err_hs = r_out_valid & out_ready & r_out_error;

    // Clear wins over set, but an error delivered in the clearing cycle survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (err_clear) begin
            r_err_sticky <= w_err_hs;
        end else if (w_err_hs) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;

`ifdef PARITY_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (err_clear) begin
            r_err_count <= w_err_hs ? CNT_W'(1) : '0;
        end else if (w_err_hs && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: directed vectors, stall/reset/clear
// sequences and a random stream checked against a queue-based reference model.
module tb_parity_checker;

  localparam int DW      = 64;
  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;
`ifdef PARITY_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic                in_parity;
  logic                odd_mode;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic                out_error;
  logic                err_sticky;
  logic [TB_CNT_W-1:0] err_count;
  logic                err_clear;

  parity_checker #(.DATA_W(DW), .CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_parity  (in_parity),
    .odd_mode   (odd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_error  (out_error),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_clear  (err_clear)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_delivered = 0;
  bit          mon_en = 1'b0;
  logic [DW:0] exp_q[$];          // {error, data}
  int          model_cnt = 0;
  bit          model_sticky = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_ov;
  logic        prev_oe;
  logic [DW-1:0] prev_od;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parity rule: count ones, derive the expected bit, compare.
  function automatic logic ref_error(input logic [DW-1:0] d, input logic p, input logic odd);
    int   ones;
    logic exp_bit;
    ones    = $countones(d);
    exp_bit = odd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    return p != exp_bit;
  endfunction

  // Monitor: inputs and outputs are stable at the falling edge, so the
  // handshakes of the coming rising edge are resolved here.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW:0] e;
      bit          hs_err;
      check("err_count", DW'(err_count), CNT_EN ? DW'(model_cnt) : '0);
      check("err_sticky", DW'(err_sticky), DW'(model_sticky));
      check("in_ready_rule", DW'(in_ready), (rst || (out_valid && !out_ready)) ? '0 : DW'(1));
      if (prev_stall) begin
        check("hold_valid", DW'(out_valid), DW'(prev_ov));
        check("hold_data", out_data, prev_od);
        check("hold_error", DW'(out_error), DW'(prev_oe));
      end
      if (rst) begin
        exp_q.delete();
        model_cnt    = 0;
        model_sticky = 1'b0;
        prev_stall   = 1'b0;
      end else begin
        hs_err = 1'b0;
        if (out_valid && out_ready) begin
          n_delivered++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", DW'(out_valid), '0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[DW-1:0]);
            check("out_error", DW'(out_error), DW'(e[DW]));
            hs_err = e[DW];
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back({ref_error(in_data, in_parity, odd_mode), in_data});
        if (err_clear) begin
          model_cnt    = hs_err ? 1 : 0;
          model_sticky = hs_err;
        end else if (hs_err) begin
          model_sticky = 1'b1;
          if (model_cnt < CNT_MAX) model_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_ov    = out_valid;
        prev_od    = out_data;
        prev_oe    = out_error;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic p, input logic m);
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    odd_mode  = m;
  endtask

  task automatic send_error_word();
    drive_word(64'h1, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          parity;
    logic          mode;
    logic          exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [DW-1:0] sw[4];
    int            base;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h0000_0000_0001_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h0000_0000_0001_FFFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_0000_AAAA_0555, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b1; err_clear = 1'b0;
    repeat (2) cycle();

    // reset state
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_error", DW'(out_error), '0);
    check("rst_err_count", DW'(err_count), '0);
    check("rst_err_sticky", DW'(err_sticky), '0);
    mon_en = 1'b1;
    rst = 1'b0;
    cycle();

    // directed vectors with exact two-cycle latency
    for (int i = 0; i < 9; i++) begin
      drive_word(vecs[i].data, vecs[i].parity, vecs[i].mode);
      cycle();
      in_valid = 1'b0;
      check("latency_early", DW'(out_valid), '0);
      cycle();
      check("vec_valid", DW'(out_valid), DW'(1));
      check("vec_data", out_data, vecs[i].data);
      check("vec_error", DW'(out_error), DW'(vecs[i].exp_err));
      cycle();
      if (i == 1) check("first_err_count", DW'(err_count), CNT_EN ? DW'(1) : '0);
    end

    // four-word stream with a three-cycle output stall in the middle
    for (int i = 0; i < 4; i++) sw[i] = {$urandom, $urandom};
    base = n_delivered;
    drive_word(sw[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cycle();
    drive_word(sw[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cycle();
    drive_word(sw[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", DW'(in_ready), '0);
      check("stall_out_data", out_data, sw[0]);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    drive_word(sw[3], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    check("stall_delivered", DW'(n_delivered - base), DW'(4));
    check("stall_queue_empty", DW'(exp_q.size()), '0);

    // clear coinciding with an error handshake, then saturation
    send_error_word();
    drive_word(64'h3, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check("clear_hs_count", DW'(err_count), CNT_EN ? DW'(1) : '0);
    check("clear_hs_sticky", DW'(err_sticky), DW'(1));
    for (int i = 0; i < 5; i++) send_error_word();
    check("sat_count", DW'(err_count), CNT_EN ? DW'(CNT_MAX) : '0);
    check("sat_sticky", DW'(err_sticky), DW'(1));

    // reset with two words in flight
    drive_word(64'h5, 1'b1, 1'b0);
    cycle();
    drive_word(64'h7, 1'b0, 1'b0);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_mid_in_ready", DW'(in_ready), '0);
    cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", DW'(in_ready), DW'(1));
    check("post_rst_out_valid", DW'(out_valid), '0);
    check("post_rst_out_data", out_data, '0);
    check("post_rst_out_error", DW'(out_error), '0);
    check("post_rst_count", DW'(err_count), '0);
    check("post_rst_sticky", DW'(err_sticky), '0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("post_rst_no_output", DW'(out_valid), '0);
    end

    // plain clear
    send_error_word();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check("clear_count", DW'(err_count), '0);
    check("clear_sticky", DW'(err_sticky), '0);

    // random stream against the reference model
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      in_parity = 1'($urandom_range(0, 1));
      odd_mode  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      err_clear = ($urandom_range(0, 19) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clear = 1'b0;
    repeat (6) cycle();
    check("final_queue_empty", DW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_checker.md
PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data word width, a multiple of 8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the error counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream word valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, DATA_W: received data word.
REQ-008 SHALL have port in_parity, input, 1: parity bit sent with the word.
REQ-009 SHALL have port odd_mode, input, 1: 0 = even check, 1 = odd check; sampled with each accepted word.
REQ-010 SHALL have port out_valid, output, 1: checked word valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-012 SHALL have port out_data, output, DATA_W: checked word, unmodified.
REQ-013 SHALL have port out_error, output, 1: parity mismatch for out_data.
REQ-014 SHALL have port err_sticky, output, 1: set on any delivered error until cleared.
REQ-015 SHALL have port err_count, output, CNT_W: saturating count of delivered errors.
REQ-016 SHALL have port err_clear, input, 1: single-cycle clear of err_sticky and err_count.

Function
REQ-017 SHALL compute expected = ^in_data when odd_mode=0, and ~^in_data when odd_mode=1; error = (in_parity != expected).
REQ-018 SHALL transfer a word on in_valid & in_ready and deliver it on out_valid & out_ready.
REQ-019 SHALL be a 2-stage pipeline. Stage 1 registers the per-byte XOR lanes (DATA_W/8 bits), data, parity and mode. Stage 2 registers the final reduce and compare. A word is output 2 cycles after acceptance when there is no stall.
REQ-020 SHALL define stall = out_valid & ~out_ready. When stall is high, both stages hold and in_ready=0. Otherwise in_ready=1, except during rst.
REQ-021 SHALL insert a bubble (stage valid=0) when nothing is accepted; bubbles SHALL NOT be counted or flagged.
REQ-022 SHALL hold out_data, out_error and out_valid stable while stall is high.
REQ-023 SHALL increment err_count and set err_sticky only on a completed output handshake with out_error=1.
REQ-024 SHALL saturate err_count at 2^CNT_W-1 with no wrap.
REQ-025 SHALL give err_clear priority: on err_clear plus a simultaneous error handshake, the result is count=1, sticky=1. Otherwise err_clear gives count=0, sticky=0.
REQ-026 SHALL sustain a throughput of one word per cycle while out_ready=1.

Reset
REQ-027 SHALL, while rst=1, force in_ready=0. At the next edge it SHALL clear out_valid, both stage valids, out_data, out_error, err_sticky and err_count to 0.
REQ-028 SHALL discard in-flight words on reset mid-operation; no partial output is produced.

Configuration
REQ-029 SHALL use macro PARITY_CHECKER_ERR_CNT_EN. When defined, err_count is implemented per REQ-023 to REQ-025. When undefined, err_count is tied to 0 with no counter flops, while err_sticky and err_clear remain functional.

Structure
REQ-030 SHALL place the DATA_W and CNT_W defaults, and a typedef for the stage-1 payload struct (data, lanes, parity, mode, valid), in package parity_pkg.
REQ-031 SHALL implement the combinational per-byte XOR in sub-module parity_lane_xor, instantiated once in stage 1.

Verification
REQ-032 SHALL cover: data 64'h0000_0000_FFFF_FFFF, parity 0, odd_mode 0 -> out_error=0 after 2 cycles; the same word with parity 1 -> out_error=1, err_count=1.
REQ-033 SHALL cover: data 64'h0000_0000_0001_FFFF, odd_mode 1, parity 0 -> out_error=0; the same word with parity 1 -> out_error=1.
REQ-034 SHALL cover: data 64'h0000_0000_AAAA_0555, even mode, parity 0 -> out_error=0, with out_data equal to in_data.
REQ-035 SHALL cover: stream of 4 words with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held, no word lost or duplicated, order preserved.
REQ-036 SHALL cover: err_clear asserted in the same cycle as an error handshake -> err_count=1, err_sticky=1; with CNT_W=2, 5 errors -> err_count=3.
REQ-037 SHALL cover: rst pulsed with 2 words in flight -> no output afterward; all outputs 0; in_ready=1 on the first cycle after rst deasserts.
